// File: rtl/btn_blink_pkg.sv
// Shared types, timing defaults and helpers for the blink scheduler.
// Round-robin selection is purely combinational.
package btn_blink_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF, ST_GAP} state_t;

    localparam int DEF_TICK_DIV  = 50000;
    localparam int DEF_ON_TICKS  = 250;
    localparam int DEF_OFF_TICKS = 250;
    localparam int DEF_GAP_TICKS = 1000;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set bit at or above ptr, wrapping at n; callers only use it when pend != 0.
    function automatic int rr_pick(input logic [7:0] pend, input int ptr, input int n);
        int   sel;
        int   j;
        logic found;
        sel   = 0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k < n && !found) begin
                j = (ptr + k) % n;
                if (((pend >> j) & 8'd1) != 8'd0) begin
                    sel   = j;
                    found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/btn_blink_tick_timer.sv
// Prescaled tick timer: o_done is high in the last cycle of a load*TICK_DIV window.
// Latency from i_start to done is exactly load*TICK_DIV cycles; no backpressure.
module tick_timer #(
    parameter int TICK_DIV = 2,
    parameter int CNT_W    = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [CNT_W-1:0] i_load,
    output logic             o_done
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic             r_run;
    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_last;
    logic             w_tick;

    assign w_tick = (r_pre == PRE_LAST);
    assign o_done = r_run && w_tick && (r_cnt == r_last);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_run  <= 1'b0;
            r_pre  <= '0;
            r_cnt  <= '0;
            r_last <= '0;
        end else if (i_start) begin
            r_run  <= 1'b1;
            r_pre  <= '0;
            r_cnt  <= '0;
            r_last <= i_load - CNT_W'(1);
        end else if (i_stop) begin
            r_run <= 1'b0;
            r_pre <= '0;
            r_cnt <= '0;
        end else if (r_run) begin
            if (w_tick) begin
                r_pre <= '0;
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end
        end
    end
endmodule

// File: rtl/btn_blink_scheduler.sv
// Shares one active-low LED among N_REQ requesters; requester i is shown as i+1 blinks.
// Grant one cycle after a request is latched; requests queue one deep per requester.
module btn_blink_scheduler
    import btn_blink_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS,
    parameter int GAP_TICKS = DEF_GAP_TICKS
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [N_REQ-1:0]          iReq,
    input  logic                      iClear,
    output logic                      oLEDn,
    output logic                      oBusy,
    output logic                      oGrantValid,
    output logic [idx_w(N_REQ)-1:0]   oGrantIdx,
    output logic [N_REQ-1:0]          oPending
);
    localparam int IDX_W = idx_w(N_REQ);
    localparam int BLK_W = $clog2(N_REQ + 1);
    localparam int MAX_T = (ON_TICKS > OFF_TICKS)
                         ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                         : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
    localparam int CNT_W = $clog2(MAX_T + 1);
    localparam logic [CNT_W-1:0] ON_L  = CNT_W'(ON_TICKS);
    localparam logic [CNT_W-1:0] OFF_L = CNT_W'(OFF_TICKS);
    localparam logic [CNT_W-1:0] GAP_L = CNT_W'(GAP_TICKS);

    state_t             r_state;
    logic [N_REQ-1:0]   r_pending;
    logic               r_led_n;
    logic               r_busy;
    logic               r_gv;
    logic [IDX_W-1:0]   r_gidx;
    logic [IDX_W-1:0]   r_rr;
    logic [BLK_W-1:0]   r_blink;

    logic [IDX_W-1:0]   w_idx;
    logic [N_REQ-1:0]   w_gmask;
    logic               w_done;
    logic               w_last;
    logic               w_start;
    logic               w_stop;
    logic [CNT_W-1:0]   w_load;

    assign oLEDn       = r_led_n;
    assign oBusy       = r_busy;
    assign oGrantValid = r_gv;
    assign oGrantIdx   = r_gidx;
    assign oPending    = r_pending;

    // The timer is restarted on every state entry so each phase length is exact.
    always_comb begin
        w_idx   = IDX_W'(rr_pick(8'(r_pending), int'(r_rr), N_REQ));
        w_gmask = N_REQ'(1) << w_idx;
        w_last  = (int'(r_blink) == int'(r_gidx));
        w_start = 1'b0;
        w_stop  = iClear;
        w_load  = ON_L;
        if (!iClear) begin
            case (r_state)
                ST_IDLE: w_start = |r_pending;
                ST_ON: begin
                    w_start = w_done;
                    w_load  = OFF_L;
                end
                ST_OFF: begin
                    w_start = w_done;
                    w_load  = w_last ? GAP_L : ON_L;
                end
                ST_GAP:  w_stop = w_done;
                default: w_stop = 1'b1;
            endcase
        end
    end

    tick_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_timer (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_start (w_start),
        .i_stop  (w_stop),
        .i_load  (w_load),
        .o_done  (w_done)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_led_n   <= 1'b1;
            r_busy    <= 1'b0;
            r_gv      <= 1'b0;
            r_gidx    <= '0;
            r_rr      <= '0;
            r_blink   <= '0;
        end else if (iClear) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_led_n   <= 1'b1;
            r_busy    <= 1'b0;
            r_gv      <= 1'b0;
            r_blink   <= '0;
        end else begin
            r_gv      <= 1'b0;
            r_pending <= r_pending | iReq;
            case (r_state)
                ST_IDLE: if (|r_pending) begin
                    r_state   <= ST_ON;
                    r_gv      <= 1'b1;
                    r_gidx    <= w_idx;
                    r_rr      <= (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
                    // A same-cycle pulse from the granted requester re-queues it.
                    r_pending <= (r_pending & ~w_gmask) | iReq;
                    r_blink   <= '0;
                    r_led_n   <= 1'b0;
                    r_busy    <= 1'b1;
                end
                ST_ON: if (w_done) begin
                    r_state <= ST_OFF;
                    r_led_n <= 1'b1;
                end
                ST_OFF: if (w_done) begin
                    r_blink <= r_blink + BLK_W'(1);
                    if (w_last) begin
                        r_state <= ST_GAP;
                    end else begin
                        r_state <= ST_ON;
                        r_led_n <= 1'b0;
                    end
                end
                ST_GAP: if (w_done) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_btn_blink_scheduler.sv
// Bench for btn_blink_scheduler: timing-level reference model plus grant scoreboard.
module tb_btn_blink_scheduler;
    localparam int N     = 4;
    localparam int TD    = 2;
    localparam int ONT   = 2;
    localparam int OFFT  = 2;
    localparam int GAPT  = 3;
    localparam int ON_C  = ONT * TD;
    localparam int OFF_C = OFFT * TD;
    localparam int GAP_C = GAPT * TD;
    localparam int PER   = ON_C + OFF_C;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         iClear = 1'b0;
    logic [N-1:0] iReq = 4'b1111;
    logic         oLEDn;
    logic         oBusy;
    logic         oGrantValid;
    logic [1:0]   oGrantIdx;
    logic [N-1:0] oPending;

    btn_blink_scheduler #(
        .N_REQ     (N),
        .TICK_DIV  (TD),
        .ON_TICKS  (ONT),
        .OFF_TICKS (OFFT),
        .GAP_TICKS (GAPT)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .iReq        (iReq),
        .iClear      (iClear),
        .oLEDn       (oLEDn),
        .oBusy       (oBusy),
        .oGrantValid (oGrantValid),
        .oGrantIdx   (oGrantIdx),
        .oPending    (oPending)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int idx;
        int at;
    } grant_t;

    grant_t       exp_q[$];
    int           cyc = 0;
    int           n_tests = 0;
    int           n_fail = 0;
    logic [N-1:0] m_pend = '0;
    int           m_rr = 0;
    int           m_idx = 0;
    int           m_g = 0;
    bit           m_act = 1'b0;

    function automatic int seq_len(input int idx);
        return (idx + 1) * PER + GAP_C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: one grant every seq_len() cycles, next grant on the edge after it ends.
    always @(posedge CLK) begin
        int j;
        cyc++;
        if (RESET) begin
            m_pend = '0;
            m_rr   = 0;
            m_act  = 1'b0;
            m_idx  = 0;
        end else if (iClear) begin
            m_pend = '0;
            m_act  = 1'b0;
        end else begin
            if (m_act && (cyc - 1) >= m_g + seq_len(m_idx))
                m_act = 1'b0;
            if (!m_act && m_pend != '0) begin
                j = -1;
                for (int k = 0; k < N; k++)
                    if (j < 0 && ((m_pend >> ((m_rr + k) % N)) & 4'd1) != 4'd0)
                        j = (m_rr + k) % N;
                m_pend = m_pend & ~(4'd1 << j);
                m_idx  = j;
                m_rr   = (j + 1) % N;
                m_g    = cyc;
                m_act  = 1'b1;
                exp_q.push_back('{j, cyc});
            end
            m_pend = m_pend | iReq;
        end
    end

    always @(negedge CLK) begin
        int     o;
        bit     e_busy;
        bit     e_lit;
        grant_t g;
        o      = cyc - m_g;
        e_busy = m_act && (o < seq_len(m_idx));
        e_lit  = e_busy && (o < (m_idx + 1) * PER) && ((o % PER) < ON_C);
        chk("led_n", 32'(oLEDn), 32'(!e_lit));
        chk("busy", 32'(oBusy), 32'(e_busy));
        chk("pending", 32'(oPending), 32'(m_pend));
        chk("grant_idx", 32'(oGrantIdx), 32'(m_idx));
        chk("grant_vld", 32'(oGrantValid), 32'(m_act && m_g == cyc));
        if (oGrantValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_grant: got idx %0d at edge %0d, expected no grant", oGrantIdx, cyc);
            end else begin
                g = exp_q.pop_front();
                chk("sb_grant_idx", 32'(oGrantIdx), 32'(g.idx));
                chk("sb_grant_edge", 32'(cyc), 32'(g.at));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse(input logic [N-1:0] v);
        @(negedge CLK);
        iReq = v;
        @(negedge CLK);
        iReq = '0;
    endtask

    task automatic clear_pulse();
        @(negedge CLK);
        iClear = 1'b1;
        @(negedge CLK);
        iClear = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        // Reset held 3 cycles with all requests asserted; they must be ignored.
        idle(3);
        RESET = 1'b0;
        iReq  = '0;
        idle(2);

        pulse(4'b0100);
        idle(35);

        pulse(4'b1011);
        idle(85);
        pulse(4'b1001);
        idle(60);

        // Re-queue while idx 1 is served, plus a dropped duplicate.
        pulse(4'b0010);
        idle(4);
        pulse(4'b0010);
        idle(2);
        pulse(4'b0010);
        idle(60);

        // Pulse landing in the grant cycle.
        pulse(4'b0010);
        pulse(4'b0010);
        idle(60);

        // Abort during the second ON of idx 3 with 0101 pending.
        pulse(4'b1000);
        pulse(4'b0101);
        idle(6);
        clear_pulse();
        pulse(4'b0001);
        idle(30);

        // Reset in the middle of GAP.
        pulse(4'b0001);
        idle(9);
        reset_pulse();
        pulse(4'b0110);
        idle(70);

        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            iReq   = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            iClear = ($urandom_range(0, 299) == 0);
            RESET  = ($urandom_range(0, 999) == 0);
        end
        @(negedge CLK);
        iReq   = '0;
        iClear = 1'b0;
        RESET  = 1'b0;
        idle(200);

        chk("grant_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/btn_blink_scheduler.md
Name: btn_blink_scheduler

Overview:
- Shares one LED between N_REQ button requesters.
- Each requester delivers single-cycle one-shot pulses, already debounced and edge-detected upstream.
- Requests are latched, granted round-robin, and served by a blink sequence on the shared LED.
- The number of blinks identifies the requester: requester i gets i+1 blinks.
- Sits between the button one-shot front ends and the LED pin driver.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- TICK_DIV, 50000: CLK cycles per timing tick.
- ON_TICKS, 250: ticks the LED is lit per blink.
- OFF_TICKS, 250: ticks the LED is dark between blinks.
- GAP_TICKS, 1000: dark ticks after the last blink, before the next grant.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- iReq  in  N_REQ  one-shot request pulses, one bit per requester.
- iClear  in  1  abort current sequence and drop all pending requests.
- oLEDn  out  1  active-low LED drive (0 = lit).
- oBusy  out  1  high while a sequence (ON/OFF/GAP) is running.
- oGrantValid  out  1  single-cycle pulse on each grant.
- oGrantIdx  out  clog2(N_REQ)  index of the requester being served; holds its value until the next grant.
- oPending  out  N_REQ  current pending-request vector.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high, sampled on the CLK rising edge.
- Reset values:
  - state=IDLE, pending=0, rr_ptr=0 (requester 0 has highest priority first).
  - oLEDn=1, oBusy=0, oGrantValid=0, oGrantIdx=0, oPending=0.
  - All counters cleared.
  - RESET asserted mid-sequence takes effect on the next edge; the LED goes dark immediately after that edge.
- Request latching:
  - iReq[i]=1 sets pending[i] on the next edge.
  - A pulse while pending[i] is already 1 is dropped (queue depth 1 per requester).
  - A pulse on requester i in the same cycle it is granted re-sets pending[i]: set wins over clear.
  - A pulse on the requester currently being served re-queues it.
- FSM states: IDLE, ON, OFF, GAP.
  - IDLE, pending!=0: grant the first set bit searching from rr_ptr upward with wrap.
    - Next edge: state=ON, oGrantValid=1 for exactly one cycle, oGrantIdx=granted index.
    - pending[idx] cleared (unless re-set as above); rr_ptr=(idx+1) mod N_REQ.
    - blink_cnt=0; oLEDn=0 from that edge.
  - ON lasts exactly ON_TICKS*TICK_DIV cycles, then moves to OFF with oLEDn=1.
  - OFF lasts OFF_TICKS*TICK_DIV cycles.
    - At the end, increment blink_cnt.
    - If blink_cnt == oGrantIdx+1, go to GAP; otherwise go back to ON.
  - GAP lasts GAP_TICKS*TICK_DIV cycles, then goes to IDLE.
  - A new grant can occur on the first IDLE cycle: IDLE dwell is 1 cycle when requests are pending.
- Timing: the tick prescaler and tick counter restart at every state entry, so durations are exact and do not depend on phase.
- oBusy=1 in ON, OFF and GAP.
- iClear:
  - Next edge: state=IDLE, pending=0, oLEDn=1, counters cleared. rr_ptr is unchanged.
  - An iReq pulse in the same cycle as iClear is dropped.
  - RESET has priority over iClear.
- Widths:
  - Tick counter sized for max(ON_TICKS, OFF_TICKS, GAP_TICKS).
  - Prescaler sized for TICK_DIV.
  - blink_cnt sized for N_REQ.
  - No overflow is possible within the parameter range.

Decomposition:
- Package btn_blink_pkg holds:
  - the state enum (IDLE/ON/OFF/GAP);
  - the index-width function (clog2);
  - the default timing constants.
- Sub-module tick_timer:
  - inputs: prescaler TICK_DIV, load value, start strobe;
  - output: done pulse.
  - Instantiated once and reloaded on each state entry.
- Round-robin selection is a combinational function kept in the package.

Test Plan:
All scenarios use TICK_DIV=2, ON_TICKS=2, OFF_TICKS=2, GAP_TICKS=3, i.e. ON=4, OFF=4, GAP=6 cycles.
- Reset check: hold RESET for 3 cycles with iReq=4'b1111. Required: oLEDn=1, oBusy=0, oPending=0 throughout; after release, the first request is serviced normally.
- Single request: pulse iReq[2] at cycle 0.
  - Cycle 1: pending=4'b0100.
  - Cycle 2: oGrantValid=1, oGrantIdx=2.
  - LED pattern: 3 lit windows of 4 cycles each, separated by 4-cycle dark windows.
  - Then a 6-cycle GAP, then oBusy=0. Total busy time = 3*(4+4)+6 = 30 cycles.
- Round-robin: pulse iReq=4'b1011 at once. Required grant order: 0, 1, 3, each with idx+1 blinks. Then pulse 4'b0001 and 4'b1000 together: grant order is 0 then 3.
- Re-queue and duplicates:
  - While idx 1 is being served, pulse iReq[1] twice. Required: pending[1]=1 after the first pulse, the second is dropped, and exactly one more idx-1 sequence follows.
  - Pulse iReq[1] in the grant cycle. Required: pending[1] stays 1.
- Abort: assert iClear during the second ON of idx 3 with pending=4'b0101. Required, next edge: oLEDn=1, oBusy=0, pending=0. Then a new iReq[0] pulse gets granted from rr_ptr=0 (unchanged by iClear).
- Reset mid-GAP: assert RESET during GAP. Required, next edge: state=IDLE, outputs at reset values, rr_ptr=0.
